// File: rtl/cache_sram_arbiter.sv
// Two-master sram-like arbiter: merges i_cache and d_cache miss ports onto one downstream bridge port.
// Optional macro CACHE_ARB_RR_EN selects round-robin on contention; default is fixed data priority.
module cache_sram_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   grant_r;
    logic   pick_s;
    logic   granted_req_s;

    assign granted_req_s = grant_r ? data_req : inst_req;

`ifdef CACHE_ARB_RR_EN
    logic rr_last_r;

    // Remember which master finished the most recent transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_r <= 1'b0;
        end else if ((state_r == ST_DATA) && mem_data_ok) begin
            rr_last_r <= grant_r;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

    // On contention the master not served last wins
    always_comb begin
        pick_s = 1'b0;
        if (inst_req && data_req) begin
            pick_s = ~rr_last_r;
        end else begin
            pick_s = data_req;
        end
    end
`else
    // Fixed priority: data wins whenever it is requesting
    always_comb begin
        pick_s = data_req;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant is loaded only on the IDLE->ADDR edge and held for the whole transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && (inst_req || data_req)) begin
            grant_r <= pick_s;
        end else begin
            grant_r <= grant_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (inst_req || data_req) begin
                    state_next_s = ST_ADDR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // A withdrawn request abandons the address phase before anything is issued
                if (!granted_req_s) begin
                    state_next_s = ST_IDLE;
                end else if (mem_addr_ok) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (mem_data_ok) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: request mux and handshake routing to the granted master
    always_comb begin
        mem_req      = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (grant_r) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end
        case (state_r)
            ST_ADDR: begin
                mem_req = granted_req_s;
                if (grant_r) begin
                    data_addr_ok = mem_addr_ok;
                end else begin
                    inst_addr_ok = mem_addr_ok;
                end
            end
            ST_DATA: begin
                if (grant_r) begin
                    data_data_ok = mem_data_ok;
                end else begin
                    inst_data_ok = mem_data_ok;
                end
            end
            ST_IDLE: begin
                mem_req = 1'b0;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: doc/cache_sram_arbiter.md
CACHE_SRAM_ARBITER -- requirements
Module: cache_sram_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed as listed below.
REQ-002 clk  in  1  single system clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 inst_req / inst_wr  in  1/1  sram-like request and write flag from the i_cache miss port.
REQ-005 inst_size  in  2  access size from the i_cache: 0 = byte, 1 = half, 2 = word.
REQ-006 inst_addr / inst_wdata  in  32/32  address and write data from the i_cache.
REQ-007 inst_rdata  out  32  read data returned to the i_cache.
REQ-008 inst_addr_ok / inst_data_ok  out  1/1  address-accepted and data-returned pulses to the i_cache.
REQ-009 data_req / data_wr / data_size / data_addr / data_wdata  in  1/1/2/32/32  the same request fields from the d_cache miss/writeback port.
REQ-010 data_rdata / data_addr_ok / data_data_ok  out  32/1/1  the same response signals to the d_cache.
REQ-011 mem_req / mem_wr / mem_size / mem_addr / mem_wdata  out  1/1/2/32/32  merged sram-like request to the downstream AXI bridge.
REQ-012 mem_rdata / mem_addr_ok / mem_data_ok  in  32/1/1  response signals from the downstream bridge.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, ADDR (request presented downstream), DATA (waiting for mem_data_ok).
REQ-014 A 1-bit grant register SHALL select the owner: 0 = inst, 1 = data.
REQ-015 Transition IDLE->ADDR: on any asserted *_req; the grant SHALL be loaded in the same edge.
REQ-016 Default arbitration SHALL be fixed data priority: data_req wins whenever both requests are high in IDLE.
REQ-017 In ADDR, mem_req SHALL equal the granted master's req, and mem_wr, mem_size, mem_addr and mem_wdata SHALL be combinationally muxed from the granted master.
REQ-018 mem_req SHALL be 0 in IDLE and DATA.
REQ-019 ADDR->DATA: on mem_addr_ok && mem_req.
REQ-020 The granted master's *_addr_ok SHALL equal mem_addr_ok in ADDR and be 0 otherwise; the other master's *_addr_ok SHALL always be 0.
REQ-021 ADDR->IDLE: if the granted master drops its req before addr_ok; no downstream transaction SHALL result.
REQ-022 The granted master's *_data_ok SHALL equal mem_data_ok in DATA only.
REQ-023 mem_data_ok in IDLE or ADDR SHALL be ignored and SHALL NOT be forwarded to either master.
REQ-024 DATA->IDLE: on mem_data_ok. Arbitration SHALL resume the next cycle, giving a minimum of 3 cycles between grants.
REQ-025 inst_rdata and data_rdata SHALL both be driven directly from mem_rdata; validity is indicated only by *_data_ok.
REQ-026 The block SHALL allow at most one transaction outstanding; a losing request SHALL be held off (addr_ok = 0) and never dropped.

Reset
REQ-027 While rst = 0: state = IDLE, grant = 0, rr_last = 0, mem_req = 0, and all *_addr_ok and *_data_ok = 0.
REQ-028 A reset assertion mid-transaction SHALL abandon the transaction; a mem_data_ok arriving after reset release SHALL be ignored per REQ-023.

Configuration
REQ-029 With macro CACHE_ARB_RR_EN defined, arbitration SHALL be round-robin when both requests are high in IDLE: the master not served last wins, tracked by rr_last, which is updated on each DATA->IDLE transition.
REQ-030 Without CACHE_ARB_RR_EN, the rr_last register SHALL be absent and REQ-016 fixed priority SHALL apply.

Verification
REQ-031 Single inst read, addr 0xBFC00000, mem_addr_ok 1 cycle after mem_req, mem_data_ok 2 cycles later with rdata 0x3C1D0001 -> inst_addr_ok pulses once, inst_data_ok pulses once with inst_rdata = 0x3C1D0001, data_* responses stay 0.
REQ-032 inst_req and data_req (write, addr 0x80001000, wdata 0xDEADBEEF) asserted in the same cycle -> data served first with mem_wr = 1 and mem_wdata = 0xDEADBEEF; inst served afterwards; with CACHE_ARB_RR_EN and last-served = data, inst is served first instead.
REQ-033 Continuous requests on both ports for 8 transactions -> with fixed priority inst starves until data_req drops; with CACHE_ARB_RR_EN grants alternate D,I,D,I,...
REQ-034 Spurious mem_data_ok = 1 while in IDLE -> no *_data_ok asserted and the state stays IDLE.
REQ-035 rst asserted in DATA, released, then mem_data_ok arrives -> ignored; the next data_req at addr 0x80002000 is granted normally.
